scan_sequencer: RTL and testbench

- Upstream driver for the 3-input active-low 2-to-4 select decoder.
- Steps a 2-bit select code (X = MSB, Y = LSB) through codes 0..3 and drives the decoder's active-low enable Z.
- Each code is enabled for a programmable dwell. Z is held high (blanking) for a programmable gap between codes, so decoder outputs never glitch between selections.
- Supports single-sweep and continuous scanning, with a per-code skip mask.

---
 rtl/scan_sequencer_if.sv | 32 +++
 rtl/scan_sequencer.sv | 153 +++++++++++++++
 tb/tb_scan_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan_sequencer.
// The dir signal exists only when SCAN_SEQUENCER_REVERSE_EN is defined.
interface scan_sequencer_if;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] mask;
`ifdef SCAN_SEQUENCER_REVERSE_EN
    logic       dir;
`endif
    logic       x;
    logic       y;
    logic       z;
    logic       busy;
    logic       done;

    modport master (
`ifdef SCAN_SEQUENCER_REVERSE_EN
        output dir,
`endif
        output start, stop, cont, mask,
        input  x, y, z, busy, done
    );

    modport slave (
`ifdef SCAN_SEQUENCER_REVERSE_EN
        input  dir,
`endif
        input  start, stop, cont, mask,
        output x, y, z, busy, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Select-code sequencer driving an active-low 2-to-4 decoder: blank, then dwell, per unmasked code.
// Optional descending scan order when SCAN_SEQUENCER_REVERSE_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start; z high, x/y hold last code
// S_BLANK | new code on x/y, z held high for BLANK cycles
// S_DWELL | decoder enabled (z low) for DWELL cycles
module scan_sequencer #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input logic            clk,
    input logic            rst,
    scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

    localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_LD = 8'((BLANK > 0) ? BLANK - 1 : 0);
    localparam state_t     ENTER_STATE = (BLANK > 0) ? S_BLANK : S_DWELL;
    localparam logic [7:0] ENTER_CNT   = (BLANK > 0) ? BLANK_LD : DWELL_LD;
    localparam logic       ENTER_Z     = (BLANK > 0);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] mask_q;
    logic       cont_q;
    logic [1:0] sel;
    logic       z_q;
    logic       busy_q;
    logic       done_q;
    logic       dir_live;
    logic       dir_q;
    logic [2:0] start_pick;
    logic [2:0] step_pick;
    logic [2:0] wrap_pick;

`ifdef SCAN_SEQUENCER_REVERSE_EN
    assign dir_live = bus.dir;
`else
    assign dir_live = 1'b0;
    assign dir_q    = 1'b0;
`endif

    // Result format: {found, code}. Ascending keeps the first hit, descending the last.
    function automatic logic [2:0] first_code(input logic [3:0] m, input logic desc);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (!m[i] && (desc || !r[2])) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [2:0] next_code(input logic [3:0] m, input logic [1:0] cur,
                                             input logic desc);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (!m[i]) begin
                if (!desc && i > int'(cur) && !r[2]) r = {1'b1, 2'(i)};
                if (desc && i < int'(cur))           r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        start_pick = first_code(bus.mask, dir_live);
        step_pick  = next_code(mask_q, sel, dir_q);
        wrap_pick  = first_code(mask_q, dir_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            mask_q <= 4'd0;
            cont_q <= 1'b0;
            sel    <= 2'd0;
            z_q    <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SCAN_SEQUENCER_REVERSE_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (!start_pick[2]) begin
                            done_q <= 1'b1;
                        end else begin
                            mask_q <= bus.mask;
                            cont_q <= bus.cont;
`ifdef SCAN_SEQUENCER_REVERSE_EN
                            dir_q  <= dir_live;
`endif
                            sel    <= start_pick[1:0];
                            busy_q <= 1'b1;
                            state  <= ENTER_STATE;
                            cnt    <= ENTER_CNT;
                            z_q    <= ENTER_Z;
                        end
                    end
                end
                S_BLANK: begin
                    if (bus.stop) begin
                        state  <= S_IDLE;
                        z_q    <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        state <= S_DWELL;
                        cnt   <= DWELL_LD;
                        z_q   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DWELL: begin
                    if (bus.stop) begin
                        state  <= S_IDLE;
                        z_q    <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        if (step_pick[2] || cont_q) begin
                            // Wrap target is always valid: start was refused for an all-masked set.
                            sel   <= step_pick[2] ? step_pick[1:0] : wrap_pick[1:0];
                            state <= ENTER_STATE;
                            cnt   <= ENTER_CNT;
                            z_q   <= ENTER_Z;
                        end else begin
                            state  <= S_IDLE;
                            z_q    <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.x    = sel[1];
    assign bus.y    = sel[0];
    assign bus.z    = z_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (BLANK=1 and BLANK=0) share one stimulus stream
// and are compared every cycle against a slot-arithmetic reference model.
module tb_scan_sequencer;
    localparam int DWELL_P = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic       stop_in;
    logic       cont_in;
    logic       dir_in;
    logic [3:0] mask_in;

    always #5 clk = ~clk;

    scan_sequencer_if ifa ();
    scan_sequencer_if ifb ();

    assign ifa.start = start_in;
    assign ifa.stop  = stop_in;
    assign ifa.cont  = cont_in;
    assign ifa.mask  = mask_in;
    assign ifb.start = start_in;
    assign ifb.stop  = stop_in;
    assign ifb.cont  = cont_in;
    assign ifb.mask  = mask_in;
`ifdef SCAN_SEQUENCER_REVERSE_EN
    assign ifa.dir = dir_in;
    assign ifb.dir = dir_in;
`endif

    scan_sequencer #(.DWELL(DWELL_P), .BLANK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    scan_sequencer #(.DWELL(DWELL_P), .BLANK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Model: a scan is a list of codes; cycle t since start sits in slot t/period,
    // the first BLANK cycles of each slot have z high.
    int         blank_p [2] = '{1, 0};
    bit         m_busy  [2];
    bit         m_done  [2];
    bit         m_cont  [2];
    int         m_t     [2];
    int         m_code  [2];
    int         m_n     [2];
    int         m_ord   [2][4];

    task automatic model_step(input int d);
        int period;
        bit rev;
        period = blank_p[d] + DWELL_P;
`ifdef SCAN_SEQUENCER_REVERSE_EN
        rev = dir_in;
`else
        rev = 1'b0;
`endif
        if (rst) begin
            m_busy[d] = 0; m_done[d] = 0; m_cont[d] = 0; m_t[d] = 0; m_code[d] = 0;
        end else if (!m_busy[d]) begin
            m_done[d] = 0;
            if (start_in) begin
                if (mask_in == 4'hF) begin
                    m_done[d] = 1;
                end else begin
                    m_n[d] = 0;
                    for (int k = 0; k < 4; k++) begin
                        int c;
                        c = rev ? 3 - k : k;
                        if (!mask_in[c]) begin
                            m_ord[d][m_n[d]] = c;
                            m_n[d]++;
                        end
                    end
                    m_busy[d] = 1;
                    m_cont[d] = cont_in;
                    m_t[d]    = 0;
                    m_code[d] = m_ord[d][0];
                end
            end
        end else begin
            m_done[d] = 0;
            if (stop_in) begin
                m_busy[d] = 0;
            end else begin
                m_t[d]++;
                if (m_t[d] / period >= m_n[d] && !m_cont[d]) begin
                    m_busy[d] = 0;
                    m_done[d] = 1;
                end else begin
                    m_code[d] = m_ord[d][(m_t[d] / period) % m_n[d]];
                end
            end
        end
    endtask

    function automatic logic [4:0] model_vec(input int d);
        logic z;
        z = m_busy[d] ? ((m_t[d] % (blank_p[d] + DWELL_P)) < blank_p[d]) : 1'b1;
        return {2'(m_code[d]), z, m_busy[d], m_done[d]};
    endfunction

    int busy_a, busy_b, zlow_a, zlow_b, done_a, done_b;

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        busy_a += int'(ifa.busy); busy_b += int'(ifb.busy);
        zlow_a += int'(!ifa.z);   zlow_b += int'(!ifb.z);
        done_a += int'(ifa.done); done_b += int'(ifb.done);
        check({phase, "_a"}, 32'({ifa.x, ifa.y, ifa.z, ifa.busy, ifa.done}), 32'(model_vec(0)));
        check({phase, "_b"}, 32'({ifb.x, ifb.y, ifb.z, ifb.busy, ifb.done}), 32'(model_vec(1)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        busy_a = 0; busy_b = 0; zlow_a = 0; zlow_b = 0; done_a = 0; done_b = 0;
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic c, input logic dr);
        mask_in  = m;
        cont_in  = c;
        dir_in   = dr;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b1; stop_in = 1'b0; cont_in = 1'b0; dir_in = 1'b0; mask_in = 4'h0;
        clear_counts();

        phase = "reset";
        run(2);
        check("reset_outs_a", 32'({ifa.x, ifa.y, ifa.z, ifa.busy, ifa.done}), 32'b00100);
        rst = 1'b0; start_in = 1'b0;
        run(2);

        phase = "full";
        clear_counts();
        pulse_start(4'b0000, 1'b0, 1'b0);
        mask_in = 4'b1111; cont_in = 1'b1;
        run(24);
        check("full_busy_len_a", 32'(busy_a), 32'd20);
        check("full_busy_len_b", 32'(busy_b), 32'd16);
        check("full_zlow_b", 32'(zlow_b), 32'd16);
        check("full_done_a", 32'(done_a), 32'd1);
        check("full_hold_xy_a", 32'({ifa.x, ifa.y}), 32'd3);

        phase = "masked";
        clear_counts();
        pulse_start(4'b1010, 1'b0, 1'b0);
        run(14);
        check("masked_busy_len_a", 32'(busy_a), 32'd10);
        check("masked_done_a", 32'(done_a), 32'd1);

        phase = "cont";
        clear_counts();
        pulse_start(4'b0001, 1'b1, 1'b0);
        start_in = 1'b1;
        run(40);
        start_in = 1'b0;
        check("cont_no_done_a", 32'(done_a), 32'd0);
        stop_in = 1'b1; tick(); stop_in = 1'b0;
        run(2);

        phase = "stop";
        clear_counts();
        pulse_start(4'b0001, 1'b1, 1'b0);
        run(7);
        check("stop_pre_xy_a", 32'({ifa.x, ifa.y, ifa.z}), 32'b100);
        stop_in = 1'b1; tick(); stop_in = 1'b0;
        check("stop_z_busy_a", 32'({ifa.z, ifa.busy, ifa.done}), 32'b100);
        run(3);
        check("stop_no_done_a", 32'(done_a), 32'd0);

        phase = "allmask";
        clear_counts();
        pulse_start(4'b1111, 1'b0, 1'b0);
        check("allmask_done_a", 32'({ifa.z, ifa.busy, ifa.done}), 32'b101);
        run(3);
        check("allmask_busy_a", 32'(busy_a), 32'd0);

        phase = "startstop";
        stop_in = 1'b1;
        pulse_start(4'b0000, 1'b0, 1'b0);
        stop_in = 1'b0;
        check("startstop_busy_a", 32'(ifa.busy), 32'd1);
        run(24);

`ifdef SCAN_SEQUENCER_REVERSE_EN
        phase = "reverse";
        pulse_start(4'b0000, 1'b0, 1'b1);
        check("reverse_first_a", 32'({ifa.x, ifa.y}), 32'd3);
        run(24);
        check("reverse_last_a", 32'({ifa.x, ifa.y}), 32'd0);
`endif

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            start_in = ($urandom_range(0, 7) == 0);
            stop_in  = ($urandom_range(0, 39) == 0);
            cont_in  = 1'($urandom);
            dir_in   = 1'($urandom);
            mask_in  = 4'($urandom);
            tick();
        end
        rst = 1'b0; start_in = 1'b0; stop_in = 1'b0;
        run(2);

        phase = "midreset";
        pulse_start(4'b0000, 1'b1, 1'b0);
        run(6);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midreset_outs_a", 32'({ifa.x, ifa.y, ifa.z, ifa.busy, ifa.done}), 32'b00100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
